// File: rtl/ccm_ctr_block_gen.sv
// ccm_ctr_block_gen: builds CCM counter blocks {flag, nonce, count} and hands them to the AES core
module ccm_ctr_block_gen #(
    parameter int WIDTH_NONCE = 100,
    parameter int WIDTH_FLAG  = 8,
    parameter int WIDTH_COUNT = 20,
    localparam int WIDTH_KEY  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH_NONCE-1:0] nonce,
    input  logic [WIDTH_FLAG-1:0]  flag,
    input  logic                   block_req,
    input  logic                   msg_last,
    input  logic                   aes_ready,
    output logic [WIDTH_KEY-1:0]   ctr_block,
    output logic                   ctr_valid,
    output logic                   ctr_is_s0,
    output logic                   busy,
    output logic                   done,
    output logic                   ctr_err
);
    typedef enum logic [2:0] {IDLE, S0_ISSUE, WAIT_REQ, ISSUE, DONE, ERR} state_t;
    state_t                 state, nxt;
    logic [WIDTH_NONCE-1:0] nonce_r;
    logic [WIDTH_FLAG-1:0]  flag_r;
    logic [WIDTH_COUNT-1:0] cnt;
    logic                   last_r, pend;
    logic                   xfer, go, serve, ovf, exhaust, issuing;
    assign ctr_block = {flag_r, nonce_r, cnt};
    assign xfer      = ctr_valid & aes_ready;
    assign go        = start & (state == IDLE || state == ERR);
    assign issuing   = state == S0_ISSUE || state == ISSUE;
    assign serve     = state == WAIT_REQ && (block_req || pend);
    assign ovf       = issuing & block_req & pend;
    assign exhaust   = serve && cnt == '0;
    // next-state selection; an overflowing request wins over a same-cycle transfer
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = go ? S0_ISSUE : IDLE;
            S0_ISSUE: nxt = ovf ? ERR : xfer ? WAIT_REQ : S0_ISSUE;
            WAIT_REQ: nxt = exhaust ? ERR : serve ? ISSUE : WAIT_REQ;
            ISSUE:    nxt = ovf ? ERR : !xfer ? ISSUE : (last_r || msg_last) ? DONE : WAIT_REQ;
            DONE:     nxt = IDLE;
            ERR:      nxt = go ? S0_ISSUE : ERR;
            default:  nxt = IDLE;
        endcase
    end
    // state, registered status outputs, and message context
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ctr_valid <= 1'b0;
            ctr_is_s0 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ctr_err   <= 1'b0;
            nonce_r   <= '0;
            flag_r    <= '0;
            cnt       <= '0;
            last_r    <= 1'b0;
            pend      <= 1'b0;
        end else begin
            state     <= nxt;
            ctr_valid <= nxt == S0_ISSUE || nxt == ISSUE;
            ctr_is_s0 <= nxt == S0_ISSUE;
            busy      <= nxt != IDLE;
            done      <= nxt == DONE;
            if (go) begin
                nonce_r <= nonce;
                flag_r  <= flag;
                cnt     <= '0;
                last_r  <= 1'b0;
                pend    <= 1'b0;
                ctr_err <= 1'b0;
            end else begin
                if (xfer)
                    cnt <= state == S0_ISSUE ? WIDTH_COUNT'(1) : cnt + 1'b1;
                if (msg_last && state != IDLE)
                    last_r <= 1'b1;
                if (serve)
                    pend <= pend & block_req;
                else if (issuing && block_req)
                    pend <= 1'b1;
                if (ovf || exhaust)
                    ctr_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ccm_ctr_block_gen.sv
// tb_ccm_ctr_block_gen: directed checks of counter block generation, handshake and error paths
module tb_ccm_ctr_block_gen;
    logic         clk = 0;
    logic         reset = 1;
    logic         start = 0, block_req = 0, msg_last = 0, aes_ready = 0;
    logic [99:0]  nonce = '0;
    logic [7:0]   flag = '0;
    logic [127:0] ctr_block;
    logic         ctr_valid, ctr_is_s0, busy, done, ctr_err;
    logic         start2 = 0, req2 = 0, last2 = 0, rdy2 = 0;
    logic [111:0] blk2;
    logic         v2, s02, busy2, done2, err2;
    int           nvec = 0, nerr = 0;

    ccm_ctr_block_gen dut (
        .clk(clk), .reset(reset), .start(start), .nonce(nonce), .flag(flag),
        .block_req(block_req), .msg_last(msg_last), .aes_ready(aes_ready),
        .ctr_block(ctr_block), .ctr_valid(ctr_valid), .ctr_is_s0(ctr_is_s0),
        .busy(busy), .done(done), .ctr_err(ctr_err)
    );

    ccm_ctr_block_gen #(.WIDTH_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start2), .nonce(100'h5), .flag(8'h11),
        .block_req(req2), .msg_last(last2), .aes_ready(rdy2),
        .ctr_block(blk2), .ctr_valid(v2), .ctr_is_s0(s02),
        .busy(busy2), .done(done2), .ctr_err(err2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        nvec++;
        if ({ctr_valid, ctr_is_s0, busy, done, ctr_err} !== 5'b00000) begin
            nerr++;
            $display("FAIL reset_status got %b exp 00000", {ctr_valid, ctr_is_s0, busy, done, ctr_err});
        end
        nvec++;
        if (ctr_block !== 128'h0) begin
            nerr++;
            $display("FAIL reset_block got %h exp 0", ctr_block);
        end
    endtask

    task automatic test_basic();
        nonce = 100'h1;
        flag = 8'h59;
        aes_ready = 1;
        start = 1;
        tick();
        start = 0;
        nvec++;
        if ({ctr_valid, ctr_is_s0, busy} !== 3'b111) begin
            nerr++;
            $display("FAIL basic_s0_status got %b exp 111", {ctr_valid, ctr_is_s0, busy});
        end
        nvec++;
        if (ctr_block !== {8'h59, 100'h1, 20'h0}) begin
            nerr++;
            $display("FAIL basic_s0_block got %h exp %h", ctr_block, {8'h59, 100'h1, 20'h0});
        end
        tick();
        nvec++;
        if ({ctr_valid, busy} !== 2'b01) begin
            nerr++;
            $display("FAIL basic_wait got %b exp 01", {ctr_valid, busy});
        end
        block_req = 1;
        msg_last = 1;
        tick();
        block_req = 0;
        msg_last = 0;
        nvec++;
        if ({ctr_valid, ctr_is_s0} !== 2'b10 || ctr_block !== {8'h59, 100'h1, 20'h1}) begin
            nerr++;
            $display("FAIL basic_a1 got v=%b s0=%b blk=%h exp v=1 s0=0 blk=%h", ctr_valid, ctr_is_s0, ctr_block, {8'h59, 100'h1, 20'h1});
        end
        tick();
        nvec++;
        if ({done, ctr_valid, busy} !== 3'b101) begin
            nerr++;
            $display("FAIL basic_done got %b exp 101", {done, ctr_valid, busy});
        end
        tick();
        nvec++;
        if ({done, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL basic_idle got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp;
        nonce = 100'hABCDE_12345_6789A_BCDEF_01234;
        flag = 8'h3A;
        exp = {8'h3A, 100'hABCDE_12345_6789A_BCDEF_01234, 20'h1};
        aes_ready = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        aes_ready = 0;
        block_req = 1;
        tick();
        block_req = 0;
        nonce = 100'h7;
        flag = 8'hFF;
        start = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 0;
            nvec++;
            if (ctr_valid !== 1'b1 || ctr_block !== exp) begin
                nerr++;
                $display("FAIL bp_hold%0d got v=%b blk=%h exp v=1 blk=%h", i, ctr_valid, ctr_block, exp);
            end
        end
        aes_ready = 1;
        tick();
        aes_ready = 0;
        nvec++;
        if ({ctr_valid, done, busy} !== 3'b001) begin
            nerr++;
            $display("FAIL bp_single_xfer got %b exp 001", {ctr_valid, done, busy});
        end
        block_req = 1;
        tick();
        block_req = 0;
        nvec++;
        if (ctr_valid !== 1'b1 || ctr_block[19:0] !== 20'h2) begin
            nerr++;
            $display("FAIL bp_next_count got v=%b cnt=%h exp v=1 cnt=2", ctr_valid, ctr_block[19:0]);
        end
        aes_ready = 1;
        msg_last = 1;
        tick();
        msg_last = 0;
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL bp_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_pending();
        nonce = 100'h42;
        flag = 8'h19;
        aes_ready = 0;
        start = 1;
        tick();
        start = 0;
        block_req = 1;
        tick();
        block_req = 0;
        tick();
        tick();
        nvec++;
        if ({ctr_valid, ctr_is_s0} !== 2'b11) begin
            nerr++;
            $display("FAIL pend_s0_held got %b exp 11", {ctr_valid, ctr_is_s0});
        end
        aes_ready = 1;
        tick();
        nvec++;
        if (ctr_valid !== 1'b0) begin
            nerr++;
            $display("FAIL pend_s0_xfer got %b exp 0", ctr_valid);
        end
        tick();
        nvec++;
        if ({ctr_valid, ctr_is_s0, ctr_err} !== 3'b100 || ctr_block !== {8'h19, 100'h42, 20'h1}) begin
            nerr++;
            $display("FAIL pend_a1 got v/s0/err=%b blk=%h exp 100 blk=%h", {ctr_valid, ctr_is_s0, ctr_err}, ctr_block, {8'h19, 100'h42, 20'h1});
        end
        msg_last = 1;
        tick();
        msg_last = 0;
        nvec++;
        if ({done, ctr_err} !== 2'b10) begin
            nerr++;
            $display("FAIL pend_done got %b exp 10", {done, ctr_err});
        end
        tick();
    endtask

    task automatic test_overflow();
        nonce = 100'h99;
        flag = 8'h01;
        aes_ready = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        aes_ready = 0;
        block_req = 1;
        tick();
        block_req = 0;
        tick();
        block_req = 1;
        tick();
        block_req = 0;
        tick();
        nvec++;
        if ({ctr_valid, ctr_err} !== 2'b10) begin
            nerr++;
            $display("FAIL ovf_one_pending got %b exp 10", {ctr_valid, ctr_err});
        end
        block_req = 1;
        tick();
        block_req = 0;
        nvec++;
        if ({ctr_err, ctr_valid, busy} !== 3'b101) begin
            nerr++;
            $display("FAIL ovf_err got %b exp 101", {ctr_err, ctr_valid, busy});
        end
        block_req = 1;
        tick();
        block_req = 0;
        nvec++;
        if ({ctr_err, ctr_valid, busy} !== 3'b101) begin
            nerr++;
            $display("FAIL ovf_sticky got %b exp 101", {ctr_err, ctr_valid, busy});
        end
        nonce = 100'hBEEF;
        flag = 8'h7E;
        start = 1;
        tick();
        start = 0;
        nvec++;
        if ({ctr_err, ctr_valid, ctr_is_s0} !== 3'b011 || ctr_block !== {8'h7E, 100'hBEEF, 20'h0}) begin
            nerr++;
            $display("FAIL ovf_restart got e/v/s0=%b blk=%h exp 011 blk=%h", {ctr_err, ctr_valid, ctr_is_s0}, ctr_block, {8'h7E, 100'hBEEF, 20'h0});
        end
    endtask

    task automatic test_reset_mid();
        aes_ready = 1;
        tick();
        aes_ready = 0;
        block_req = 1;
        tick();
        block_req = 0;
        nvec++;
        if (ctr_valid !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_setup got %b exp 1", ctr_valid);
        end
        reset = 1;
        tick();
        reset = 0;
        nvec++;
        if ({ctr_valid, ctr_is_s0, busy, done, ctr_err} !== 5'b00000 || ctr_block !== 128'h0) begin
            nerr++;
            $display("FAIL rst_mid_clear got %b blk=%h exp 00000 blk=0", {ctr_valid, ctr_is_s0, busy, done, ctr_err}, ctr_block);
        end
        tick();
        nvec++;
        if ({done, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL rst_mid_nodone got %b exp 00", {done, busy});
        end
        nonce = 100'h3;
        flag = 8'h22;
        start = 1;
        tick();
        start = 0;
        nvec++;
        if ({ctr_valid, ctr_is_s0} !== 2'b11 || ctr_block !== {8'h22, 100'h3, 20'h0}) begin
            nerr++;
            $display("FAIL rst_mid_restart got %b blk=%h exp 11 blk=%h", {ctr_valid, ctr_is_s0}, ctr_block, {8'h22, 100'h3, 20'h0});
        end
    endtask

    task automatic test_exhaust();
        rdy2 = 1;
        start2 = 1;
        tick();
        start2 = 0;
        tick();
        for (int i = 1; i <= 15; i++) begin
            req2 = 1;
            tick();
            req2 = 0;
            nvec++;
            if (v2 !== 1'b1 || blk2 !== {8'h11, 100'h5, 4'(i)}) begin
                nerr++;
                $display("FAIL exh_blk%0d got v=%b blk=%h exp v=1 blk=%h", i, v2, blk2, {8'h11, 100'h5, 4'(i)});
            end
            tick();
        end
        nvec++;
        if ({v2, err2} !== 2'b00) begin
            nerr++;
            $display("FAIL exh_all_ok got %b exp 00", {v2, err2});
        end
        req2 = 1;
        tick();
        req2 = 0;
        nvec++;
        if ({err2, v2, busy2} !== 3'b101) begin
            nerr++;
            $display("FAIL exh_err got %b exp 101", {err2, v2, busy2});
        end
        tick();
        nvec++;
        if ({err2, v2} !== 2'b10) begin
            nerr++;
            $display("FAIL exh_no_valid got %b exp 10", {err2, v2});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pending();
        test_overflow();
        test_reset_mid();
        test_exhaust();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ccm_ctr_block_gen.md
Name: ccm_ctr_block_gen

Overview:
- Generates CCM counter blocks A_i = {flag, nonce, count} and issues them to the AES core for encryption.
- The encrypted results return to the CTR data buffer on its encrypt_data/encrypt_en inputs.
- Issues A_0 (the MAC-tag keystream block) first, then one A_i per block request from the data buffer, until the last message block.
- Sits between the CTR data buffer (request side) and the AES core (accept side).

Parameters:
- WIDTH_NONCE, 100: nonce width in bits.
- WIDTH_FLAG, 8: flag field width in bits.
- WIDTH_COUNT, 20: counter field width in bits.
- WIDTH_KEY, WIDTH_NONCE+WIDTH_FLAG+WIDTH_COUNT (local, =128): counter block width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a message and latches nonce/flag.
- nonce  in  WIDTH_NONCE  sampled on an accepted start.
- flag  in  WIDTH_FLAG  sampled on an accepted start.
- block_req  in  1  pulse from the data buffer (its max_in_en_val); one keystream block needed.
- msg_last  in  1  pulse; the message's final byte has been received.
- aes_ready  in  1  AES core accepts ctr_block in a cycle where ctr_valid=1.
- ctr_block  out  WIDTH_KEY  counter block to the AES core.
- ctr_valid  out  1  ctr_block is valid.
- ctr_is_s0  out  1  qualifies ctr_valid; current block is A_0.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse after the final message block is accepted.
- ctr_err  out  1  sticky; set on counter exhaustion or request overflow.

Behaviour:
- Field mapping:
  - ctr_block[WIDTH_KEY-1 -: WIDTH_FLAG] = flag_r.
  - Next WIDTH_NONCE bits = nonce_r.
  - ctr_block[WIDTH_COUNT-1:0] = cnt.
  - cnt is unsigned.
- Reset values: all registers and outputs 0; ctr_block=0; FSM in IDLE.
- FSM states: IDLE, S0_ISSUE, WAIT_REQ, ISSUE, DONE, ERR.
- IDLE:
  - start=1: latch nonce/flag, cnt<=0, clear last_r/pend; go to S0_ISSUE.
  - block_req and msg_last are ignored in IDLE.
- S0_ISSUE:
  - ctr_valid=1, ctr_is_s0=1.
  - On aes_ready: cnt<=1, go to WAIT_REQ.
- WAIT_REQ:
  - Enter ISSUE on block_req=1, or if pend=1 (clearing pend).
  - Latency: block_req in cycle t gives ctr_valid=1 in cycle t+1.
- ISSUE:
  - ctr_valid=1, ctr_is_s0=0, ctr_block carries the current cnt.
  - ctr_block must be stable while ctr_valid=1 and aes_ready=0.
  - On aes_ready: cnt<=cnt+1. Go to DONE if last_r=1, else to WAIT_REQ.
- DONE: done=1 for exactly one cycle; go to IDLE.
- ERR:
  - ctr_valid=0, busy=1.
  - Leave only via reset or start; start in ERR behaves as in IDLE and clears ctr_err.
- Valid/ready handshake:
  - Transfer occurs iff ctr_valid & aes_ready.
  - ctr_valid falls in the cycle after the transfer.
  - ctr_valid never drops without a transfer.
- Pending request: block_req arriving in S0_ISSUE or ISSUE sets pend (depth 1).
- Request overflow: block_req while pend=1 and not being consumed sets ctr_err; FSM goes to ERR.
- msg_last:
  - Sets last_r in any non-IDLE state.
  - last_r governs the next accepted non-S0 block, or the current block if it is in ISSUE.
  - msg_last with block_req in the same cycle: both are honoured.
- Counter exhaustion:
  - If a request is to be served with cnt=0, i.e. the counter wrapped after the all-ones block was issued: no block is issued, ctr_err<=1, go to ERR.
  - Accepting the all-ones block itself is legal.
- start while busy and not in ERR: ignored.
- Reset mid-transfer: ctr_valid drops in the next cycle; no done pulse is produced.

Test Plan:
- Basic: reset; start with nonce=100'h1, flag=8'h59, aes_ready=1 -> ctr_valid=1 with ctr_is_s0=1 and ctr_block={8'h59,100'h1,20'h0}. Then one block_req with msg_last -> ctr_block count=1, then done pulse, then busy=0.
- Backpressure: aes_ready=0 for 5 cycles during ISSUE -> ctr_valid and ctr_block held constant; single transfer when aes_ready=1; cnt increments by exactly 1.
- Pending: block_req during S0_ISSUE with aes_ready delayed 3 cycles -> A_0 issued, then A_1 issued with no further block_req; ctr_err=0.
- Overflow: two block_req pulses during stalled ISSUE plus one more -> ctr_err=1, FSM in ERR, ctr_valid=0; start clears ctr_err and reissues A_0.
- Exhaustion: force WIDTH_COUNT=4, issue 15 blocks (count 1..15) -> all accepted; 16th block_req -> ctr_err=1, no ctr_valid.
- Reset mid-ISSUE: assert reset while ctr_valid=1 -> next cycle all outputs 0; start afterwards restarts at count 0.
